// File: rtl/cu_pkg.sv
//------------------------------------------------------------------------------
// Module : cu_pkg
// Brief  : Opcodes, control encodings and E-stage control bundle for the
//          pipelined control unit.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cu_pkg;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  localparam logic [1:0] c_res_alu = 2'b00;
  localparam logic [1:0] c_res_mem = 2'b01;
  localparam logic [1:0] c_res_pc4 = 2'b10;

  localparam logic [2:0] c_imm_i = 3'b000;
  localparam logic [2:0] c_imm_s = 3'b001;
  localparam logic [2:0] c_imm_b = 3'b010;
  localparam logic [2:0] c_imm_j = 3'b011;
  localparam logic [2:0] c_imm_u = 3'b100;

  localparam logic [2:0] c_aluop_add   = 3'b000;
  localparam logic [2:0] c_aluop_sub   = 3'b001;
  localparam logic [2:0] c_aluop_funct = 3'b010;
  localparam logic [2:0] c_aluop_lui   = 3'b011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLT  = 4'h5,
    ALU_SLTU = 4'h6,
    ALU_SLL  = 4'h7,
    ALU_SRL  = 4'h8,
    ALU_SRA  = 4'h9,
    ALU_LUI  = 4'hA
  } alu_ctrl_e;

  // All-zero value of this bundle is the pipeline bubble.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic       jalr;
    alu_ctrl_e  alu_control;
    logic [2:0] funct3;
  } e_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
//------------------------------------------------------------------------------
// Module : alu_decoder
// Brief  : ALUOp/funct3/funct7 to ALU control.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_decoder
  import cu_pkg::*;
#(
  parameter int ALU_OP_WIDTH = 3
) (
  input  logic [ALU_OP_WIDTH-1:0] alu_op,
  input  logic [2:0]              funct3,
  input  logic                    funct7_5,
  input  logic                    op_5,
  output alu_ctrl_e               alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_WIDTH'(c_aluop_sub): alu_control = ALU_SUB;
      ALU_OP_WIDTH'(c_aluop_lui): alu_control = ALU_LUI;
      ALU_OP_WIDTH'(c_aluop_funct): begin
        case (funct3)
          // Only R-type (op[5]=1) uses funct7 to select subtract; addi never does.
          3'b000:  alu_control = (funct7_5 & op_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/branch_unit.sv
//------------------------------------------------------------------------------
// Module : branch_unit
// Brief  : Branch condition from ALU flags of A-B; produces PC redirect.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module branch_unit (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       neg,
  input  logic       carry,
  input  logic       ovf,
  input  logic       branch,
  input  logic       jump,
  output logic       pc_src
);

  logic w_cond;

  always_comb begin
    w_cond = 1'b0;
    case (funct3)
      3'b000:  w_cond = zero;
      3'b001:  w_cond = ~zero;
      3'b100:  w_cond = neg ^ ovf;
      3'b101:  w_cond = ~(neg ^ ovf);
      3'b110:  w_cond = ~carry;
      3'b111:  w_cond = carry;
      default: w_cond = 1'b0;
    endcase
  end

  assign pc_src = jump | (branch & w_cond);

endmodule

`default_nettype wire

// File: rtl/main_decoder.sv
//------------------------------------------------------------------------------
// Module : main_decoder
// Brief  : Opcode to datapath controls; unknown opcodes decode to all zero.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module main_decoder
  import cu_pkg::*;
#(
  parameter int OP_WIDTH      = 7,
  parameter int ALU_OP_WIDTH  = 3,
  parameter int IMM_SRC_WIDTH = 3
) (
  input  logic [OP_WIDTH-1:0]      op,
  output logic                     reg_write,
  output logic [1:0]               result_src,
  output logic                     mem_write,
  output logic                     jump,
  output logic                     branch,
  output logic                     alu_src,
  output logic                     jalr,
  output logic [IMM_SRC_WIDTH-1:0] imm_src,
  output logic [ALU_OP_WIDTH-1:0]  alu_op
);

  always_comb begin
    reg_write  = 1'b0;
    result_src = c_res_alu;
    mem_write  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    jalr       = 1'b0;
    imm_src    = IMM_SRC_WIDTH'(c_imm_i);
    alu_op     = ALU_OP_WIDTH'(c_aluop_add);
    case (op)
      OP_WIDTH'(c_op_load): begin
        reg_write  = 1'b1;
        result_src = c_res_mem;
        alu_src    = 1'b1;
      end
      OP_WIDTH'(c_op_store): begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_src   = IMM_SRC_WIDTH'(c_imm_s);
      end
      OP_WIDTH'(c_op_rtype): begin
        reg_write = 1'b1;
        alu_op    = ALU_OP_WIDTH'(c_aluop_funct);
      end
      OP_WIDTH'(c_op_itype): begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = ALU_OP_WIDTH'(c_aluop_funct);
      end
      OP_WIDTH'(c_op_lui): begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        imm_src   = IMM_SRC_WIDTH'(c_imm_u);
        alu_op    = ALU_OP_WIDTH'(c_aluop_lui);
      end
      OP_WIDTH'(c_op_branch): begin
        branch  = 1'b1;
        imm_src = IMM_SRC_WIDTH'(c_imm_b);
        alu_op  = ALU_OP_WIDTH'(c_aluop_sub);
      end
      OP_WIDTH'(c_op_jal): begin
        reg_write  = 1'b1;
        result_src = c_res_pc4;
        jump       = 1'b1;
        imm_src    = IMM_SRC_WIDTH'(c_imm_j);
      end
      OP_WIDTH'(c_op_jalr): begin
        reg_write  = 1'b1;
        result_src = c_res_pc4;
        jump       = 1'b1;
        jalr       = 1'b1;
        alu_src    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pipelined_control_unit.sv
//------------------------------------------------------------------------------
// Module : pipelined_control_unit
// Brief  : D-stage decode with E/M/W control pipeline registers.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipelined_control_unit
  import cu_pkg::*;
#(
  parameter int OP_WIDTH       = 7,
  parameter int FUNCT3_WIDTH   = 3,
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int IMM_SRC_WIDTH  = 3,
  parameter int ALU_OP_WIDTH   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OP_WIDTH-1:0]       opD,
  input  logic [FUNCT3_WIDTH-1:0]   funct3D,
  input  logic                      funct7_5D,
  input  logic                      FlushE,
  input  logic                      ZeroE,
  input  logic                      NE,
  input  logic                      CE,
  input  logic                      VE,
  output logic [IMM_SRC_WIDTH-1:0]  ImmSrcD,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControlE,
  output logic                      ALUSrcE,
  output logic                      PCSrcE,
  output logic                      PCTargetSrcE,
  output logic [1:0]                ResultSrcE,
  output logic                      MemWriteM,
  output logic [FUNCT3_WIDTH-1:0]   funct3M,
  output logic                      RegWriteM,
  output logic [1:0]                ResultSrcW,
  output logic                      RegWriteW
);

  e_ctrl_t                   w_d;
  e_ctrl_t                   r_e;
  logic [ALU_OP_WIDTH-1:0]   w_alu_op;
  logic                      r_m_reg_write;
  logic [1:0]                r_m_result_src;
  logic                      r_m_mem_write;
  logic [2:0]                r_m_funct3;
  logic                      r_w_reg_write;
  logic [1:0]                r_w_result_src;

  main_decoder #(
    .OP_WIDTH      (OP_WIDTH),
    .ALU_OP_WIDTH  (ALU_OP_WIDTH),
    .IMM_SRC_WIDTH (IMM_SRC_WIDTH)
  ) u_main_decoder (
    .op         (opD),
    .reg_write  (w_d.reg_write),
    .result_src (w_d.result_src),
    .mem_write  (w_d.mem_write),
    .jump       (w_d.jump),
    .branch     (w_d.branch),
    .alu_src    (w_d.alu_src),
    .jalr       (w_d.jalr),
    .imm_src    (ImmSrcD),
    .alu_op     (w_alu_op)
  );

  alu_decoder #(
    .ALU_OP_WIDTH (ALU_OP_WIDTH)
  ) u_alu_decoder (
    .alu_op      (w_alu_op),
    .funct3      (3'(funct3D)),
    .funct7_5    (funct7_5D),
    .op_5        (opD[5]),
    .alu_control (w_d.alu_control)
  );

  assign w_d.funct3 = 3'(funct3D);

  // Reset has priority over flush; both load the all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_e            <= '0;
      r_m_reg_write  <= 1'b0;
      r_m_result_src <= 2'b00;
      r_m_mem_write  <= 1'b0;
      r_m_funct3     <= 3'b000;
      r_w_reg_write  <= 1'b0;
      r_w_result_src <= 2'b00;
    end else begin
      r_e            <= FlushE ? '0 : w_d;
      r_m_reg_write  <= r_e.reg_write;
      r_m_result_src <= r_e.result_src;
      r_m_mem_write  <= r_e.mem_write;
      r_m_funct3     <= r_e.funct3;
      r_w_reg_write  <= r_m_reg_write;
      r_w_result_src <= r_m_result_src;
    end
  end

  branch_unit u_branch_unit (
    .funct3 (r_e.funct3),
    .zero   (ZeroE),
    .neg    (NE),
    .carry  (CE),
    .ovf    (VE),
    .branch (r_e.branch),
    .jump   (r_e.jump),
    .pc_src (PCSrcE)
  );

  assign ALUControlE  = ALU_CTRL_WIDTH'(r_e.alu_control);
  assign ALUSrcE      = r_e.alu_src;
  assign PCTargetSrcE = r_e.jalr;
  assign ResultSrcE   = r_e.result_src;
  assign MemWriteM    = r_m_mem_write;
  assign funct3M      = FUNCT3_WIDTH'(r_m_funct3);
  assign RegWriteM    = r_m_reg_write;
  assign ResultSrcW   = r_w_result_src;
  assign RegWriteW    = r_w_reg_write;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
//------------------------------------------------------------------------------
// Module : tb_pipelined_control_unit
// Brief  : Directed self-checking bench for pipelined_control_unit.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipelined_control_unit;

  localparam logic [6:0] c_nop    = 7'b0000000;
  localparam logic [6:0] c_load   = 7'b0000011;
  localparam logic [6:0] c_store  = 7'b0100011;
  localparam logic [6:0] c_rtype  = 7'b0110011;
  localparam logic [6:0] c_branch = 7'b1100011;
  localparam logic [6:0] c_jalr   = 7'b1100111;
  localparam logic [6:0] c_jal    = 7'b1101111;

  logic       clk;
  logic       rst;
  logic [6:0] opD;
  logic [2:0] funct3D;
  logic       funct7_5D;
  logic       FlushE;
  logic       ZeroE, NE, CE, VE;
  logic [2:0] ImmSrcD;
  logic [3:0] ALUControlE;
  logic       ALUSrcE, PCSrcE, PCTargetSrcE;
  logic [1:0] ResultSrcE;
  logic       MemWriteM;
  logic [2:0] funct3M;
  logic       RegWriteM;
  logic [1:0] ResultSrcW;
  logic       RegWriteW;

  int n_checks = 0;
  int n_fail   = 0;

  pipelined_control_unit dut (
    .clk          (clk),
    .rst          (rst),
    .opD          (opD),
    .funct3D      (funct3D),
    .funct7_5D    (funct7_5D),
    .FlushE       (FlushE),
    .ZeroE        (ZeroE),
    .NE           (NE),
    .CE           (CE),
    .VE           (VE),
    .ImmSrcD      (ImmSrcD),
    .ALUControlE  (ALUControlE),
    .ALUSrcE      (ALUSrcE),
    .PCSrcE       (PCSrcE),
    .PCTargetSrcE (PCTargetSrcE),
    .ResultSrcE   (ResultSrcE),
    .MemWriteM    (MemWriteM),
    .funct3M      (funct3M),
    .RegWriteM    (RegWriteM),
    .ResultSrcW   (ResultSrcW),
    .RegWriteW    (RegWriteW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    opD       = op;
    funct3D   = f3;
    funct7_5D = f75;
  endtask

  task automatic set_flags(input logic z, input logic n, input logic c, input logic v);
    ZeroE = z; NE = n; CE = c; VE = v;
  endtask

  function automatic logic [31:0] all_outs();
    return {14'b0, ALUControlE, ALUSrcE, PCSrcE, PCTargetSrcE, ResultSrcE,
            MemWriteM, funct3M, RegWriteM, ResultSrcW, RegWriteW};
  endfunction

  initial begin
    rst = 1'b1;
    FlushE = 1'b0;
    drive(c_nop, 3'b000, 1'b0);
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();

    // Reset state; ImmSrcD still follows opD
    drive(c_store, 3'b010, 1'b0);
    #1;
    check_eq("reset_outputs", all_outs(), 32'd0);
    check_eq("reset_immsrc_store", 32'(ImmSrcD), 32'd1);
    rst = 1'b0;

    // add: RegWriteW exactly 3 cycles after decode
    drive(c_rtype, 3'b000, 1'b0);
    tick();
    check_eq("add_aluctrl_e", 32'(ALUControlE), 32'h0);
    check_eq("add_alusrc_e", 32'(ALUSrcE), 32'd0);
    check_eq("add_regwrite_w_at1", 32'(RegWriteW), 32'd0);
    drive(c_nop, 3'b000, 1'b0);
    tick();
    check_eq("add_regwrite_m", 32'(RegWriteM), 32'd1);
    check_eq("add_regwrite_w_at2", 32'(RegWriteW), 32'd0);
    tick();
    check_eq("add_regwrite_w_at3", 32'(RegWriteW), 32'd1);
    check_eq("add_resultsrc_w", 32'(ResultSrcW), 32'd0);
    tick();
    check_eq("add_regwrite_w_at4", 32'(RegWriteW), 32'd0);

    // sub selects ALU subtract
    drive(c_rtype, 3'b000, 1'b1);
    tick();
    check_eq("sub_aluctrl_e", 32'(ALUControlE), 32'h1);

    // Branches
    drive(c_branch, 3'b000, 1'b0);
    set_flags(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("beq_immsrc", 32'(ImmSrcD), 32'd2);
    tick();
    check_eq("beq_taken_pcsrc", 32'(PCSrcE), 32'd1);
    check_eq("beq_taken_target", 32'(PCTargetSrcE), 32'd0);
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("beq_not_taken", 32'(PCSrcE), 32'd0);

    drive(c_branch, 3'b110, 1'b0);
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("bltu_c0_taken", 32'(PCSrcE), 32'd1);

    drive(c_branch, 3'b101, 1'b0);
    set_flags(1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    check_eq("bge_n1v1_taken", 32'(PCSrcE), 32'd1);

    drive(c_branch, 3'b100, 1'b0);
    tick();
    check_eq("blt_n1v1_not", 32'(PCSrcE), 32'd0);

    drive(c_branch, 3'b010, 1'b0);
    set_flags(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check_eq("br_f3_010_never", 32'(PCSrcE), 32'd0);
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);

    // jalr
    drive(c_jalr, 3'b000, 1'b0);
    tick();
    check_eq("jalr_pcsrc", 32'(PCSrcE), 32'd1);
    check_eq("jalr_target", 32'(PCTargetSrcE), 32'd1);
    check_eq("jalr_resultsrc_e", 32'(ResultSrcE), 32'd2);
    drive(c_nop, 3'b000, 1'b0);
    tick();
    tick();
    check_eq("jalr_resultsrc_w", 32'(ResultSrcW), 32'd2);
    check_eq("jalr_regwrite_w", 32'(RegWriteW), 32'd1);

    // lw (kept), sw, then lw flushed on E entry
    drive(c_load, 3'b010, 1'b0);
    tick();
    check_eq("lw_resultsrc_e", 32'(ResultSrcE), 32'd1);
    drive(c_store, 3'b010, 1'b0);
    tick();
    drive(c_load, 3'b010, 1'b0);
    FlushE = 1'b1;
    tick();
    check_eq("sw_memwrite_m", 32'(MemWriteM), 32'd1);
    check_eq("sw_funct3_m", 32'(funct3M), 32'd2);
    check_eq("lw_flushed_resultsrc_e", 32'(ResultSrcE), 32'd0);
    check_eq("lw_kept_regwrite_w", 32'(RegWriteW), 32'd1);
    check_eq("lw_kept_resultsrc_w", 32'(ResultSrcW), 32'd1);
    FlushE = 1'b0;
    drive(c_nop, 3'b000, 1'b0);
    tick();
    check_eq("bubble_memwrite_m", 32'(MemWriteM), 32'd0);
    check_eq("sw_regwrite_w", 32'(RegWriteW), 32'd0);
    tick();
    check_eq("lw_flushed_regwrite_w", 32'(RegWriteW), 32'd0);

    // Flush with taken branch already in E: redirect still seen this cycle
    drive(c_branch, 3'b000, 1'b0);
    set_flags(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    FlushE = 1'b1;
    #1;
    check_eq("flush_taken_same_cycle", 32'(PCSrcE), 32'd1);
    tick();
    check_eq("flush_bubble_pcsrc", 32'(PCSrcE), 32'd0);
    FlushE = 1'b0;

    // Unknown opcode behaves as NOP
    drive(7'b1111111, 3'b000, 1'b0);
    #1;
    check_eq("unk_immsrc", 32'(ImmSrcD), 32'd0);
    tick();
    check_eq("unk_e_ctrls", {22'b0, ResultSrcE, ALUSrcE, ALUControlE, PCSrcE, PCTargetSrcE}, 32'd0);
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);

    // jal
    drive(c_jal, 3'b000, 1'b0);
    #1;
    check_eq("jal_immsrc", 32'(ImmSrcD), 32'd3);
    tick();
    check_eq("jal_pcsrc", 32'(PCSrcE), 32'd1);
    check_eq("jal_target", 32'(PCTargetSrcE), 32'd0);

    // Reset with a store in E, flush also asserted
    drive(c_store, 3'b010, 1'b0);
    tick();
    check_eq("st_in_e_resultsrc", 32'(ALUSrcE), 32'd1);
    rst = 1'b1;
    FlushE = 1'b1;
    tick();
    check_eq("rst_mid_memwrite_m", 32'(MemWriteM), 32'd0);
    check_eq("rst_mid_all_outputs", all_outs(), 32'd0);
    check_eq("rst_mid_immsrc", 32'(ImmSrcD), 32'd1);
    rst = 1'b0;
    FlushE = 1'b0;
    drive(c_nop, 3'b000, 1'b0);
    tick();
    check_eq("post_rst_memwrite_m", 32'(MemWriteM), 32'd0);
    check_eq("post_rst_regwrite_w", 32'(RegWriteW), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
